vga_sync_core: RTL and testbench

//  Video timing core for the VGA path. Divides the system clock into a pixel tick and runs
//  the hc/vc scan counters. Generates active-low hsync/vsync, delayed to match upstream pixel latency.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_sync_delay.sv | 38 +++
 rtl/vga_sync_core.sv | 142 ++++++++++++++
 tb/tb_vga_sync_core.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, derived scan limits and the scan-count type.
package vga_timing_pkg;

    // 640x480 @ 60 Hz defaults (pixels / lines)
    localparam int unsigned HD_DEF = 640;
    localparam int unsigned HF_DEF = 16;
    localparam int unsigned HB_DEF = 48;
    localparam int unsigned HR_DEF = 96;
    localparam int unsigned VD_DEF = 480;
    localparam int unsigned VF_DEF = 10;
    localparam int unsigned VB_DEF = 33;
    localparam int unsigned VR_DEF = 2;

    localparam int unsigned HT = HD_DEF + HF_DEF + HB_DEF + HR_DEF;
    localparam int unsigned VT = VD_DEF + VF_DEF + VB_DEF + VR_DEF;

    localparam int unsigned HS_START = HD_DEF + HF_DEF;
    localparam int unsigned HS_END   = HD_DEF + HF_DEF + HR_DEF - 1;
    localparam int unsigned VS_START = VD_DEF + VF_DEF;
    localparam int unsigned VS_END   = VD_DEF + VF_DEF + VR_DEF - 1;

    localparam int unsigned SCAN_W = 11;

    typedef logic [SCAN_W-1:0] scan_cnt_t;

    // True when c lies in the inclusive window [lo, hi].
    function automatic logic in_window(scan_cnt_t c, int unsigned lo, int unsigned hi);
        return (c >= scan_cnt_t'(lo)) && (c <= scan_cnt_t'(hi));
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Tick-enabled shift register that delays the sync/display flags to match upstream latency.
module vga_sync_delay #(
    parameter int unsigned W    = 3,
    parameter int unsigned PIPE = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] rst_val_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (PIPE == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = ^{clk_i, rst_ni, en_i, rst_val_i};
        assign q_o = d_i;
    end else begin : g_shift
        logic [W-1:0] stage_q [PIPE];

        // Shift one stage per pixel tick; every stage clears to the inactive value.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(PIPE); i++) begin
                    stage_q[i] <= rst_val_i;
                end
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < int'(PIPE); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[PIPE-1];
    end

endmodule

// File: rtl/vga_sync_core.sv
// VGA timing core: pixel-tick divider, hc/vc scan counters, delayed syncs and blanked colour.
module vga_sync_core
    import vga_timing_pkg::*;
#(
    parameter int unsigned CD   = 12,
    parameter int unsigned DIV  = 4,
    parameter int unsigned HD   = HD_DEF,
    parameter int unsigned HF   = HF_DEF,
    parameter int unsigned HB   = HB_DEF,
    parameter int unsigned HR   = HR_DEF,
    parameter int unsigned VD   = VD_DEF,
    parameter int unsigned VF   = VF_DEF,
    parameter int unsigned VB   = VB_DEF,
    parameter int unsigned VR   = VR_DEF,
    parameter int unsigned PIPE = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CD-1:0] vga_si_rgb,
    output logic [10:0]   hc,
    output logic [10:0]   vc,
    output logic          p_tick,
    output logic          frame_start,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic [CD-1:0] rgb
);

    localparam int unsigned HTot    = HD + HF + HB + HR;
    localparam int unsigned VTot    = VD + VF + VB + VR;
    localparam int unsigned HsStart = HD + HF;
    localparam int unsigned HsEnd   = HD + HF + HR - 1;
    localparam int unsigned VsStart = VD + VF;
    localparam int unsigned VsEnd   = VD + VF + VR - 1;
    localparam int unsigned CntW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
    localparam scan_cnt_t       HMax   = scan_cnt_t'(HTot - 1);
    localparam scan_cnt_t       VMax   = scan_cnt_t'(VTot - 1);

    if (HTot - 1 >= 2048 || VTot - 1 >= 2048) begin : g_bad_scan
        $fatal(1, "vga_sync_core: HT-1 and VT-1 must fit in 11 bits");
    end
    if (DIV < 1) begin : g_bad_div
        $fatal(1, "vga_sync_core: DIV must be >= 1");
    end
    if (PIPE > 7) begin : g_bad_pipe
        $fatal(1, "vga_sync_core: PIPE must be 0..7");
    end

    logic [CntW-1:0] cnt_q, cnt_d;
    scan_cnt_t       hc_q, hc_d;
    scan_cnt_t       vc_q, vc_d;
    logic            cnt_hit, tick;
    logic            h_on, v_on, hs_raw, vs_raw;
    logic [2:0]      dly_in, dly_out;
    logic            hsync_q, vsync_q, von_q;
    logic [CD-1:0]   rgb_q;

    // The reset input is expected to deassert synchronously; gating the tick with it keeps
    // p_tick/frame_start low during reset even when DIV=1 holds the divider at its terminal count.
    assign cnt_hit = (cnt_q == CntMax);
    assign tick    = reset_n & cnt_hit;

    // Next-state for the pixel divider and the scan counters.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        hc_d  = hc_q;
        vc_d  = vc_q;
        if (cnt_hit) begin
            cnt_d = '0;
        end
        if (tick) begin
            if (hc_q == HMax) begin
                hc_d = '0;
                vc_d = (vc_q == VMax) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    // Divider and scan counter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            hc_q  <= '0;
            vc_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            hc_q  <= hc_d;
            vc_q  <= vc_d;
        end
    end

    // Raw flags for the current scan position.
    always_comb begin
        h_on   = hc_q < scan_cnt_t'(HD);
        v_on   = vc_q < scan_cnt_t'(VD);
        hs_raw = ~in_window(hc_q, HsStart, HsEnd);
        vs_raw = ~in_window(vc_q, VsStart, VsEnd);
        dly_in = {hs_raw, vs_raw, h_on & v_on};
    end

    vga_sync_delay #(
        .W    (3),
        .PIPE (PIPE)
    ) u_delay (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .en_i      (tick),
        .rst_val_i (3'b110),
        .d_i       (dly_in),
        .q_o       (dly_out)
    );

    // Output register: syncs follow the delay line, colour is blanked outside the display area.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            von_q   <= 1'b0;
            rgb_q   <= '0;
        end else if (tick) begin
            hsync_q <= dly_out[2];
            vsync_q <= dly_out[1];
            von_q   <= dly_out[0];
            rgb_q   <= dly_out[0] ? vga_si_rgb : '0;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign p_tick      = tick;
    assign frame_start = tick & (hc_q == '0) & (vc_q == '0);
    assign video_on    = von_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_sync_core.sv
// Self-checking bench for vga_sync_core using a shrunk raster so whole frames fit in a short run.
module tb_vga_sync_core;

    localparam int CD = 12;
    localparam int HD = 16, HF = 2, HB = 3, HR = 4;
    localparam int VD = 6,  VF = 2, VB = 2, VR = 2;
    localparam int HT = HD + HF + HB + HR;
    localparam int VT = VD + VF + VB + VR;
    localparam int FT = HT * VT;

    typedef struct {
        int e;
        int hc;
        int vc;
        int pt;
        int fs;
        int hs;
        int vs;
        int von;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [2:0][CD-1:0]   rgb_in;
    logic [2:0][CD-1:0]   rgb_o;
    logic [2:0][10:0]     hc_o;
    logic [2:0][10:0]     vc_o;
    logic [2:0]           pt_o, fs_o, von_o, hs_o, vs_o;

    int total = 0;
    int bad   = 0;
    int e     = 0;
    bit run   = 1'b0;
    int last_in [3];
    bit te      [3];
    int hs_cnt  [3];
    int vs_cnt  [3];
    int nz_cnt  [3];
    int tk_cnt  [3];
    bit seen    [3];
    bit prev_von;
    int prev_rgb;
    vec_t tbl[$];

    always #5 clk = ~clk;

    // dut 0: DIV=4 PIPE=0 random colour; dut 1: DIV=4 PIPE=2 colour=hc; dut 2: DIV=1 PIPE=1 FFF
    vga_sync_core #(
        .CD(CD), .DIV(4), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
        .VD(VD), .VF(VF), .VB(VB), .VR(VR), .PIPE(0)
    ) u_p0 (
        .clk(clk), .reset_n(reset_n), .vga_si_rgb(rgb_in[0]), .hc(hc_o[0]), .vc(vc_o[0]),
        .p_tick(pt_o[0]), .frame_start(fs_o[0]), .video_on(von_o[0]), .hsync(hs_o[0]),
        .vsync(vs_o[0]), .rgb(rgb_o[0])
    );

    vga_sync_core #(
        .CD(CD), .DIV(4), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
        .VD(VD), .VF(VF), .VB(VB), .VR(VR), .PIPE(2)
    ) u_p2 (
        .clk(clk), .reset_n(reset_n), .vga_si_rgb(rgb_in[1]), .hc(hc_o[1]), .vc(vc_o[1]),
        .p_tick(pt_o[1]), .frame_start(fs_o[1]), .video_on(von_o[1]), .hsync(hs_o[1]),
        .vsync(vs_o[1]), .rgb(rgb_o[1])
    );

    vga_sync_core #(
        .CD(CD), .DIV(1), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
        .VD(VD), .VF(VF), .VB(VB), .VR(VR), .PIPE(1)
    ) u_div1 (
        .clk(clk), .reset_n(reset_n), .vga_si_rgb(rgb_in[2]), .hc(hc_o[2]), .vc(vc_o[2]),
        .p_tick(pt_o[2]), .frame_start(fs_o[2]), .video_on(von_o[2]), .hsync(hs_o[2]),
        .vsync(vs_o[2]), .rgb(rgb_o[2])
    );

    function automatic int div_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic int pipe_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
    endfunction

    // Raster rules for a linear position p within a frame.
    function automatic int von_p(input int p);
        return ((p % HT) < HD && (p / HT) < VD) ? 1 : 0;
    endfunction

    function automatic int hs_p(input int p);
        int h;
        h = p % HT;
        return (h >= HD + HF && h < HD + HF + HR) ? 0 : 1;
    endfunction

    function automatic int vs_p(input int p);
        int v;
        v = p / HT;
        return (v >= VD + VF && v < VD + VF + VR) ? 0 : 1;
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d e=%0d actual=%0h required=%0h", nm, k, e, act, exp);
        end
    endtask

    // After e clocks out of reset, m = e/DIV ticks have happened; pins show position m-1-PIPE.
    task automatic check_dut(input int k);
        int dv, pp, m, p, q, pq;
        int ehc, evc, ept, efs, ehs, evs, evon, ergb;
        dv = div_of(k);
        pp = pipe_of(k);
        ehc = 0; evc = 0; ept = 0; efs = 0; ehs = 1; evs = 1; evon = 0; ergb = 0;
        if (run) begin
            m   = e / dv;
            p   = m % FT;
            ehc = p % HT;
            evc = p / HT;
            ept = (e % dv == dv - 1) ? 1 : 0;
            efs = (ept == 1 && p == 0) ? 1 : 0;
            q   = m - 1 - pp;
            if (q >= 0) begin
                pq   = q % FT;
                ehs  = hs_p(pq);
                evs  = vs_p(pq);
                evon = von_p(pq);
                ergb = (evon == 1) ? last_in[k] : 0;
            end
        end
        chk("hc", k, int'(hc_o[k]), ehc);
        chk("vc", k, int'(vc_o[k]), evc);
        chk("p_tick", k, int'(pt_o[k]), ept);
        chk("frame_start", k, int'(fs_o[k]), efs);
        chk("hsync", k, int'(hs_o[k]), ehs);
        chk("vsync", k, int'(vs_o[k]), evs);
        chk("video_on", k, int'(von_o[k]), evon);
        chk("rgb", k, int'(rgb_o[k]), ergb);
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 3; k++) begin
            hs_cnt[k] = 0; vs_cnt[k] = 0; nz_cnt[k] = 0; tk_cnt[k] = 0; seen[k] = 1'b0;
            te[k] = 1'b0;
        end
        prev_von = 1'b0;
        prev_rgb = 0;
    endtask

    // Per-cycle model checks, per-frame totals, then drive the next inputs.
    task automatic eval();
        int m1;
        for (int k = 0; k < 3; k++) check_dut(k);
        if (run) begin
            for (int k = 0; k < 3; k++) begin
                if (te[k]) begin
                    hs_cnt[k] += (hs_o[k] == 1'b0) ? 1 : 0;
                    vs_cnt[k] += (vs_o[k] == 1'b0) ? 1 : 0;
                    nz_cnt[k] += (rgb_o[k] != '0) ? 1 : 0;
                    tk_cnt[k]++;
                    if (k == 1) begin
                        if (von_o[1] && !prev_von) chk("first_px", 1, int'(rgb_o[1]), 0);
                        if (!von_o[1] && prev_von) chk("last_px", 1, prev_rgb, HD - 1);
                        prev_von = von_o[1];
                        prev_rgb = int'(rgb_o[1]);
                    end
                end
                if (fs_o[k]) begin
                    if (seen[k]) begin
                        chk("frame_ticks", k, tk_cnt[k], FT);
                        chk("hs_low_ticks", k, hs_cnt[k], HR * VT);
                        chk("vs_low_ticks", k, vs_cnt[k], VR * HT);
                        if (k == 2) chk("lit_pixels", k, nz_cnt[k], HD * VD);
                    end
                    seen[k] = 1'b1;
                    hs_cnt[k] = 0; vs_cnt[k] = 0; nz_cnt[k] = 0; tk_cnt[k] = 0;
                end
            end
        end
        rgb_in[0] = CD'($urandom);
        m1 = e / 4;
        rgb_in[1] = (run && m1 >= 2) ? CD'(((m1 - 2) % FT) % HT) : '0;
        rgb_in[2] = '1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (run) begin
            e++;
            for (int k = 0; k < 3; k++) begin
                te[k] = (e % div_of(k) == 0);
                if (te[k]) last_in[k] = int'(rgb_in[k]);
            end
        end else begin
            for (int k = 0; k < 3; k++) te[k] = 1'b0;
        end
        eval();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        run = 1'b1;
        e = 0;
        clear_stats();
        #1;
        eval();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached e=%0d", e);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected values for the PIPE=0, DIV=4 instance at selected clock counts after release.
        tbl.push_back('{0,    0,  0,  0, 0, 1, 1, 0});
        tbl.push_back('{3,    0,  0,  1, 1, 1, 1, 0});
        tbl.push_back('{4,    1,  0,  0, 0, 1, 1, 1});
        tbl.push_back('{64,   16, 0,  0, 0, 1, 1, 1});
        tbl.push_back('{68,   17, 0,  0, 0, 1, 1, 0});
        tbl.push_back('{75,   18, 0,  1, 0, 1, 1, 0});
        tbl.push_back('{76,   19, 0,  0, 0, 0, 1, 0});
        tbl.push_back('{88,   22, 0,  0, 0, 0, 1, 0});
        tbl.push_back('{92,   23, 0,  0, 0, 1, 1, 0});
        tbl.push_back('{100,  0,  1,  0, 0, 1, 1, 0});
        tbl.push_back('{104,  1,  1,  0, 0, 1, 1, 1});
        tbl.push_back('{804,  1,  8,  0, 0, 1, 0, 0});
        tbl.push_back('{1000, 0,  10, 0, 0, 1, 0, 0});
        tbl.push_back('{1004, 1,  10, 0, 0, 1, 1, 0});
        tbl.push_back('{1203, 0,  0,  1, 1, 1, 1, 0});

        reset_n = 1'b0;
        rgb_in  = '0;
        for (int k = 0; k < 3; k++) last_in[k] = 0;
        clear_stats();

        // Reset held for 10 clocks.
        repeat (10) step();

        release_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            while (e < tbl[i].e) step();
            chk("tbl_hc", 0, int'(hc_o[0]), tbl[i].hc);
            chk("tbl_vc", 0, int'(vc_o[0]), tbl[i].vc);
            chk("tbl_p_tick", 0, int'(pt_o[0]), tbl[i].pt);
            chk("tbl_frame_start", 0, int'(fs_o[0]), tbl[i].fs);
            chk("tbl_hsync", 0, int'(hs_o[0]), tbl[i].hs);
            chk("tbl_vsync", 0, int'(vs_o[0]), tbl[i].vs);
            chk("tbl_video_on", 0, int'(von_o[0]), tbl[i].von);
        end
        while (e < 3 * FT * 4 + 20) step();

        // Mid-frame reset: run into a new frame, stop at hc=10, vc=4 of the DIV=4 instances.
        while (e < 4 * FT * 4 + 4 * (4 * HT + 10)) step();
        chk("pre_reset_video_on", 0, int'(von_o[0]), 1);
        #1;
        reset_n = 1'b0;
        run = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check_dut(k);
        repeat (5) step();

        release_reset();
        while (e < 2 * FT * 4 + 20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
